// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit sequencer: state encoding, frame
// timing constants and character helpers.
package uart_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_POP    = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP1  = 3'd5;
    localparam logic [2:0] ST_STOP2  = 3'd6;

    localparam int STOP_TICKS_FULL = 16;
    localparam int STOP_TICKS_HALF = 8;

    // Character length in bits, 5..8, from the LCR word-length field.
    function automatic logic [3:0] char_len(input logic [1:0] bits);
        return 4'd5 + {2'b00, bits};
    endfunction

    // Bits above the character length never contribute to parity.
    function automatic logic parity_bit(input logic [7:0] data, input logic [3:0] n,
                                        input logic eps, input logic sp);
        logic [7:0] masked;
        masked = data & (8'hFF >> (4'd8 - n));
        if (sp)
            return ~eps;
        return eps ? ^masked : ~^masked;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops characters from the TX FIFO and serialises
// them onto stx_o using the 16x baud enable.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int FIFO_WIDTH     = 8,
    parameter int FIFO_COUNTER_W = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [1:0]                lcr_bits,
    input  logic                      lcr_stop,
    input  logic                      lcr_pe,
    input  logic                      lcr_eps,
    input  logic                      lcr_sp,
    input  logic                      lcr_bc,
    input  logic [FIFO_COUNTER_W-1:0] tf_count,
    input  logic [FIFO_WIDTH-1:0]     tf_data,
    output logic                      tf_pop,
    output logic                      stx_o,
    output logic                      tx_busy,
    output logic                      tx_empty,
    output logic [2:0]                tstate
);

    logic [2:0] state, state_nxt;
    logic [3:0] tick, tick_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [1:0] bits_q;
    logic       stop_q, pe_q, par_q;
    logic       stx_q, stx_nxt;
    logic [7:0] char_in;
    logic       bit_end;
    logic [3:0] stop2_last;
    logic       fifo_has_data;

    assign char_in       = 8'(tf_data);
    assign fifo_has_data = (tf_count != '0);
    assign bit_end       = enable && (tick == 4'd15);
    assign stop2_last    = (bits_q == 2'b00) ? 4'(STOP_TICKS_HALF - 1)
                                             : 4'(STOP_TICKS_FULL - 1);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt   = state;
        tick_nxt    = tick;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        stx_nxt     = 1'b1;

        if (state != ST_IDLE && state != ST_POP && enable)
            tick_nxt = tick + 4'd1;

        case (state)
            ST_IDLE:   if (fifo_has_data) state_nxt = ST_POP;
            ST_POP: begin
                state_nxt   = ST_START;
                tick_nxt    = '0;
                bit_cnt_nxt = '0;
                shreg_nxt   = char_in;
            end
            ST_START:  if (bit_end) state_nxt = ST_DATA;
            ST_DATA: begin
                if (bit_end) begin
                    shreg_nxt   = shreg >> 1;
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if ({1'b0, bit_cnt} == char_len(bits_q) - 4'd1)
                        state_nxt = pe_q ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: if (bit_end) state_nxt = ST_STOP1;
            ST_STOP1:  if (bit_end) state_nxt = stop_q ? ST_STOP2 : ST_IDLE;
            ST_STOP2:  if (enable && tick == stop2_last) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase

        // Line level is decided from the upcoming state so stx_o comes straight off a flop.
        case (state_nxt)
            ST_START:  stx_nxt = 1'b0;
            ST_DATA:   stx_nxt = shreg_nxt[0];
            ST_PARITY: stx_nxt = par_q;
            default:   stx_nxt = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every flop here,
    // including the character shift register, has a defined reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            bits_q  <= '0;
            stop_q  <= 1'b0;
            pe_q    <= 1'b0;
            par_q   <= 1'b0;
            stx_q   <= 1'b1;
        end else begin
            state   <= state_nxt;
            tick    <= tick_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            stx_q   <= stx_nxt;
            if (state == ST_POP) begin
                bits_q <= lcr_bits;
                stop_q <= lcr_stop;
                pe_q   <= lcr_pe;
                par_q  <= parity_bit(char_in, char_len(lcr_bits), lcr_eps, lcr_sp);
            end
        end
    end

    assign tf_pop   = (state == ST_POP) && fifo_has_data;
    assign stx_o    = stx_q & ~lcr_bc;
    assign tx_busy  = (state != ST_IDLE);
    assign tx_empty = !fifo_has_data && (state == ST_IDLE);
    assign tstate   = state;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: expected frames are queued at load time
// and a monitor checks each frame's line waveform when the DUT pops a character.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] lcr_bits;
    logic       lcr_stop, lcr_pe, lcr_eps, lcr_sp, lcr_bc;
    logic [4:0] tf_count;
    logic [7:0] tf_data;
    logic       tf_pop, stx_o, tx_busy, tx_empty;
    logic [2:0] tstate;

    uart_tx_ctrl #(.FIFO_WIDTH(8), .FIFO_COUNTER_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .lcr_bits(lcr_bits), .lcr_stop(lcr_stop), .lcr_pe(lcr_pe),
        .lcr_eps(lcr_eps), .lcr_sp(lcr_sp), .lcr_bc(lcr_bc),
        .tf_count(tf_count), .tf_data(tf_data), .tf_pop(tf_pop),
        .stx_o(stx_o), .tx_busy(tx_busy), .tx_empty(tx_empty), .tstate(tstate)
    );

    always #5 clk = ~clk;

    // Baud enable: every clk, or every 4th clk when en_slow is set.
    logic       en_slow;
    logic [1:0] en_cnt = '0;
    int         cyc = 0;
    always @(posedge clk) begin
        en_cnt <= en_cnt + 2'd1;
        cyc    <= cyc + 1;
    end
    assign enable = !en_slow || (en_cnt == 2'd0);

    // FIFO model: stimulus appends, pops advance the read pointer.
    logic [7:0] load_data [64];
    logic [7:0] load_n;
    logic [7:0] rd_ptr = '0;
    always @(posedge clk) if (tf_pop) rd_ptr <= rd_ptr + 8'd1;
    assign tf_count = 5'(load_n - rd_ptr);
    assign tf_data  = load_data[rd_ptr[5:0]];

    typedef struct packed {
        logic [15:0] lv;         // line level per bit slot, slot 0 first
        int          nslots;
        int          last_ticks; // enables in the final stop slot
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pop_cnt  = 0;
    int   pop_time [16];
    bit   mon_busy = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push_char(input logic [7:0] d, input logic [15:0] lv,
                             input int nslots, input int last_ticks);
        exp_t e;
        e.lv = lv; e.nslots = nslots; e.last_ticks = last_ticks;
        exp_q.push_back(e);
        load_data[load_n[5:0]] = d;
        load_n = load_n + 8'd1;
    endtask

    task automatic set_lcr(input logic [1:0] bits, input logic stop, input logic pe,
                           input logic eps, input logic sp);
        lcr_bits = bits; lcr_stop = stop; lcr_pe = pe; lcr_eps = eps; lcr_sp = sp;
    endtask

    // Walks one frame in enable units; the POP-cycle enable is not counted.
    task automatic run_frame(input exp_t e, input int fnum);
        int  total, cnt, first_bad;
        bit  aborted, done;
        logic exp_bit;
        total = 16 * (e.nslots - 1) + e.last_ticks;
        cnt = 0; first_bad = -1; aborted = 0; done = 0;
        mon_busy = 1'b1;
        while (!done) begin
            @(negedge clk); #1;
            if (!rst_n) begin
                aborted = 1; done = 1;
            end else begin
                exp_bit = lcr_bc ? 1'b0 : e.lv[cnt / 16];
                if (first_bad < 0 && (stx_o !== exp_bit || tx_busy !== 1'b1))
                    first_bad = cnt;
                if (enable) cnt++;
                if (cnt == total) done = 1;
            end
        end
        check($sformatf("frame%0d_first_bad_tick", fnum), first_bad, -1);
        if (!aborted) begin
            @(negedge clk); #1;
            if (rst_n)
                check($sformatf("frame%0d_end_busy_stx", fnum),
                      int'({tx_busy, stx_o}), int'({1'b0, !lcr_bc}));
        end
        mon_busy = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (rst_n && tf_pop) begin
                pop_time[pop_cnt[3:0]] = cyc;
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    run_frame(e, pop_cnt);
                end
            end
        end
    end

    task automatic wait_idle(output int busy_clks);
        bit done;
        done = 0; busy_clks = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk); #2;
            if (tx_busy) busy_clks++;
            if (!tx_busy && tf_count == 0 && !mon_busy) done = 1;
        end
        if (!done) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_pop();
        bit seen;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk); #1;
            if (tf_pop) seen = 1;
        end
        if (!seen) check("pop_timeout", 0, 1);
    endtask

    initial begin : stimulus
        int busy, pops_before, bad;
        rst_n = 1'b0; en_slow = 1'b0; lcr_bc = 1'b0; load_n = '0;
        set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_tf_pop",   int'(tf_pop),   0);
        check("rst_stx",      int'(stx_o),    1);
        check("rst_busy",     int'(tx_busy),  0);
        check("rst_tstate",   int'(tstate),   0);
        check("rst_tx_empty", int'(tx_empty), 1);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1, 0x55
        push_char(8'h55, 16'h02AA, 10, 16);
        wait_idle(busy);
        check("8n1_busy_clks", busy, 161);
        check("8n1_tx_empty", int'(tx_empty), 1);
        check("8n1_pops", pop_cnt, 1);

        // 7E1 / 7O1 / stick parity
        @(negedge clk); set_lcr(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        push_char(8'h41, 16'h0282, 10, 16);
        wait_idle(busy);
        check("7e1_busy_clks", busy, 161);
        @(negedge clk); set_lcr(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        push_char(8'h41, 16'h0382, 10, 16);
        wait_idle(busy);
        @(negedge clk); set_lcr(2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
        push_char(8'h43, 16'h0286, 10, 16);
        wait_idle(busy);

        // 5-bit even parity: bits above the character are ignored
        @(negedge clk); set_lcr(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        push_char(8'hE3, 16'h0086, 8, 16);
        wait_idle(busy);
        check("5e1_busy_clks", busy, 129);

        // 5-bit, 1.5 stop bits, enable every 4th clk
        @(negedge clk); en_slow = 1'b1; set_lcr(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        push_char(8'h1F, 16'h00FE, 8, 8);
        wait_idle(busy);
        check("5n15_busy_min", int'(busy >= 1 + 120 * 4 - 3), 1);

        // Back-to-back 8N1 frames
        @(negedge clk); en_slow = 1'b0; set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        pops_before = pop_cnt;
        push_char(8'hA5, 16'h034A, 10, 16);
        push_char(8'h3C, 16'h0278, 10, 16);
        wait_idle(busy);
        check("b2b_busy_clks", busy, 322);
        check("b2b_pops", pop_cnt - pops_before, 2);
        check("b2b_pop_spacing",
              pop_time[(pops_before + 1) % 16] - pop_time[pops_before % 16], 162);

        // Break control asserted mid-DATA
        @(negedge clk);
        push_char(8'h55, 16'h02AA, 10, 16);
        wait_pop();
        repeat (56) @(negedge clk);
        lcr_bc = 1'b1;
        #1;
        check("bc_stx_low", int'(stx_o), 0);
        check("bc_fsm_in_data", int'(tstate), 3);
        check("bc_tx_empty", int'(tx_empty), 0);
        repeat (20) @(negedge clk);
        lcr_bc = 1'b0;
        wait_idle(busy);

        // Reset in the 4th data bit
        @(negedge clk);
        push_char(8'h0F, 16'h021E, 10, 16);
        wait_pop();
        repeat (72) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_stx", int'(stx_o), 1);
        check("midrst_tstate", int'(tstate), 0);
        check("midrst_busy", int'(tx_busy), 0);
        check("midrst_tf_pop", int'(tf_pop), 0);
        pops_before = pop_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (tf_pop || tx_busy || !stx_o) bad++;
        end
        check("postrst_quiet_clks_bad", bad, 0);
        check("postrst_pops", pop_cnt - pops_before, 0);

        check("scoreboard_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit sequencer sitting between uart_tfifo and the STX pin.
- Whenever the TX FIFO holds data, it pops one character, latches it with the current line-control settings, and serialises it: start, 5–8 data bits LSB first, optional parity, then 1/1.5/2 stop bits.
- Bit timing comes from the shared 16x baud enable. Status outputs feed the UART line-status logic (THRE/TEMT) and interrupt logic.

Parameters:
- FIFO_WIDTH, 8, width of tf_data; characters narrower than 8 bits use the low bits.
- FIFO_COUNTER_W, 5, width of tf_count; must match the tfifo instance.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  16x baud tick; one clk wide; may be high on every clk
- lcr_bits  in  2  character length: 00=5, 01=6, 10=7, 11=8 bits
- lcr_stop  in  1  0 = 1 stop bit; 1 = 1.5 stop bits if 5-bit characters, else 2
- lcr_pe  in  1  parity enable
- lcr_eps  in  1  even-parity select
- lcr_sp  in  1  stick parity
- lcr_bc  in  1  break control; forces the line low
- tf_count  in  FIFO_COUNTER_W  tfifo occupancy
- tf_data  in  FIFO_WIDTH  tfifo head word (combinational read of the bottom entry)
- tf_pop  out  1  tfifo pop strobe; exactly one clk wide
- stx_o  out  1  serial output
- tx_busy  out  1  a frame is in progress (state != IDLE)
- tx_empty  out  1  tf_count==0 and state==IDLE (TEMT)
- tstate  out  3  current state encoding, for debug/status

Behaviour:
- Reset values:
  - state=IDLE, tf_pop=0, stx_o=1, tx_busy=0.
  - tx_empty follows tf_count combinationally.
  - Shift register, latched LCR fields, bit counter and tick counter all 0.
- States: IDLE(0), POP(1), START(2), DATA(3), PARITY(4), STOP1(5), STOP2(6).
- IDLE → POP:
  - Transition occurs on any clk with tf_count!=0; enable is not required.
- POP (one cycle):
  - Assert tf_pop.
  - Capture tf_data into an 8-bit shift register.
  - Capture lcr_bits/stop/pe/eps/sp into frame-local copies.
  - Clear both counters; go to START.
  - LCR changes after POP do not affect the current frame.
  - enable is ignored in the POP cycle.
- Bit timing:
  - A 4-bit tick counter increments on enable.
  - A bit period ends on the enable that takes the counter from 15 to 0, i.e. 16 enables per bit.
- START: stx=0 for one bit period → DATA.
- DATA:
  - stx = shreg[0]; shift right at the end of each bit.
  - 3-bit counter; leave after (5+lcr_bits) bits.
  - Next state is PARITY if pe, else STOP1.
- PARITY bit value:
  - sp=1: bit = ~eps.
  - sp=0, eps=1: bit = XOR of the n data bits (even parity).
  - sp=0, eps=0: bit = XNOR of the n data bits (odd parity).
  - Parity is computed at POP from the masked character; bits above n are ignored.
- STOP1:
  - stx=1 for 16 ticks.
  - If lcr_stop=0 → IDLE.
  - If lcr_stop=1 → STOP2.
- STOP2:
  - stx=1 for 8 ticks when the character is 5 bits, else 16 ticks → IDLE.
- Back-to-back frames:
  - IDLE→POP→START costs 2 clks between frames.
  - No enable-phase alignment is required.
- lcr_bc=1:
  - stx_o=0 immediately (combinational override, registered output path) in all states.
  - The FSM keeps running and FIFO draining continues.
- tf_pop:
  - Never asserted when tf_count==0.
  - Never asserted in a state other than POP.
- A FIFO reset asserted mid-frame does not abort the frame; the latched character completes.
- rst_n deasserted-to-asserted mid-frame:
  - Immediate IDLE, stx_o=1, and no pop on the first cycle after reset release unless tf_count!=0.
- stx_o is driven from a flop (glitch-free), except for the lcr_bc override.

Decomposition:
- Package uart_tx_pkg holds:
  - state encoding constants;
  - character-length decode (5+lcr_bits);
  - stop-tick constants (16, 8);
  - a parity function (data, n, eps, sp).
- No sub-module; single FSM plus counters, roughly 200 lines.

Test Plan:
- 8N1 (lcr_bits=11, pe=0, stop=0), enable on every clk, tf_count=1, tf_data=0x55:
  - tf_pop for 1 clk.
  - stx: 16 clks low, then 1,0,1,0,1,0,1,0 (16 clks each), then 16 clks high.
  - tx_busy high for 161 clks; tx_empty=1 after (tf_count=0).
- 7E1 with 0x41 (lcr_bits=10, pe=1, eps=1, sp=0): data 1,0,0,0,0,0,1, then parity=0.
  - With eps=0, parity=1.
  - With sp=1, eps=1, parity=0.
- 5-bit with lcr_stop=1, enable every 4th clk, char 0x1F: stop high for 24 enables (96 clks) before return to IDLE.
- tf_count=2 (0xA5, 0x3C) in 8N1: two pops, 162 clks apart; second frame starts 2 clks after the first STOP1 ends; LSB order correct for both.
- lcr_bc toggled mid-DATA: stx_o=0 while set; FSM continues; frame ends at the normal time.
- rst_n pulsed in the 4th data bit: stx_o=1 and state=IDLE during reset; with tf_count=0 held, no tf_pop and no activity afterwards.
